// File: rtl/qnigma_pkg.sv
// Shared types and defaults for the qnigma TCP datapath.
package qnigma_pkg;

    localparam int unsigned SEQ_W             = 32;
    localparam int unsigned LEN_W             = 16;
    localparam int unsigned MSS_DEFAULT       = 1460;
    localparam int unsigned RTO_MS_DEFAULT    = 200;
    localparam int unsigned FLUSH_MS_DEFAULT  = 5;
    localparam int unsigned MAX_RETRY_DEFAULT = 5;

    typedef struct packed {
        logic [31:0] rem_ip;
        logic [15:0] rem_port;
        logic [15:0] loc_port;
        logic [31:0] loc_seq;
        logic [31:0] rem_seq;
    } tcb_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XMIT
    } tx_ctl_state_t;

    function automatic logic [SEQ_W-1:0] seq_min(input logic [SEQ_W-1:0] a,
                                                 input logic [SEQ_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/qnigma_tcp_tx_ctl_if.sv
// Segment request and payload stream between tx control (master) and the TX engine (slave).
interface qnigma_tcp_tx_ctl_if;
    import qnigma_pkg::*;

    logic             send_req;
    logic             send_acc;
    logic [SEQ_W-1:0] send_seq;
    logic [LEN_W-1:0] send_len;
    logic             pld_rd;
    logic [7:0]       pld_dat;
    logic             pld_val;
    logic             send_done;

    modport master (
        output send_req, send_seq, send_len, pld_dat, pld_val,
        input  send_acc, pld_rd, send_done
    );

    modport slave (
        input  send_req, send_seq, send_len, pld_dat, pld_val,
        output send_acc, pld_rd, send_done
    );

endinterface

// File: rtl/qnigma_tcp_tx_buf.sv
// Simple dual-port payload byte RAM with a registered 1-cycle read port.
module qnigma_tcp_tx_buf #(
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_dat,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_dat
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [7:0] mem [DEPTH];
    logic [7:0] rd_dat_q;
    logic [7:0] rd_dat_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    always_comb begin
        rd_dat_d = rd_dat_q;
        if (rd_en) begin
            rd_dat_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_dat_q <= '0;
        end else begin
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/qnigma_tcp_tx_ctl.sv
// TCP transmit control: buffers user payload, forms MSS/flush segments, tracks ACKs, retransmits on RTO.
module qnigma_tcp_tx_ctl
    import qnigma_pkg::*;
#(
    parameter int unsigned BUF_AW    = 12,
    parameter int unsigned MSS       = MSS_DEFAULT,
    parameter int unsigned FLUSH_MS  = FLUSH_MS_DEFAULT,
    parameter int unsigned RTO_MS    = RTO_MS_DEFAULT,
    parameter int unsigned MAX_RETRY = MAX_RETRY_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_ms,
    input  tcb_t             tcb,
    input  logic             ini,
    input  logic [7:0]       in_dat,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [SEQ_W-1:0] rem_ack,
    input  logic             rem_ack_val,
    output logic [SEQ_W-1:0] loc_seq,
    output logic             fail,
    qnigma_tcp_tx_ctl_if.master eng
);

    localparam int unsigned    RTO_W   = $clog2(RTO_MS + 1);
    localparam int unsigned    FL_W    = $clog2(FLUSH_MS + 1);
    localparam int unsigned    RT_W    = $clog2(MAX_RETRY + 1);
    localparam logic [SEQ_W-1:0] DEPTH   = 32'd1 << BUF_AW;
    localparam logic [SEQ_W-1:0] MSS_SEQ = 32'(MSS);

    tx_ctl_state_t     state_q, state_d;
    logic [SEQ_W-1:0]  wr_q, wr_d;
    logic [SEQ_W-1:0]  una_q, una_d;
    logic [SEQ_W-1:0]  nxt_q, nxt_d;
    logic [SEQ_W-1:0]  send_seq_q, send_seq_d;
    logic [LEN_W-1:0]  send_len_q, send_len_d;
    logic              send_req_q, send_req_d;
    logic              retx_q, retx_d;
    logic              fail_q, fail_d;
    logic              init_q, init_d;
    logic              pld_val_q, pld_val_d;
    logic [BUF_AW-1:0] rd_q, rd_d;
    logic [RTO_W-1:0]  rto_q, rto_d;
    logic [FL_W-1:0]   flush_q, flush_d;
    logic [RT_W-1:0]   retry_q, retry_d;

    logic [SEQ_W-1:0]  lock_c;
    logic [SEQ_W-1:0]  unsent_c;
    logic [SEQ_W-1:0]  inflight_c;
    logic [SEQ_W-1:0]  ack_off_c;
    logic              wr_en_c;
    logic              rd_en_c;
    logic              ack_ok_c;
    logic              rto_exp_c;
    logic              unused_tcb;

    assign unused_tcb = ^{tcb.rem_ip, tcb.rem_port, tcb.loc_port, tcb.rem_seq};

    // A retransmission in flight pins its bytes even if an ACK moves una past them.
    assign lock_c     = (retx_q && (state_q != IDLE)) ? send_seq_q : una_q;
    assign in_rdy     = init_q && !fail_q && ((wr_q - lock_c) < DEPTH);
    assign wr_en_c    = in_val && in_rdy && !ini;
    assign rd_en_c    = (state_q == XMIT) && eng.pld_rd && !ini;
    assign unsent_c   = wr_q - nxt_q;
    assign inflight_c = nxt_q - una_q;
    assign ack_off_c  = rem_ack - una_q;
    assign ack_ok_c   = rem_ack_val && (ack_off_c != '0) && (ack_off_c <= inflight_c);
    assign rto_exp_c  = rto_q >= RTO_W'(RTO_MS);

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        una_d      = una_q;
        nxt_d      = nxt_q;
        send_seq_d = send_seq_q;
        send_len_d = send_len_q;
        send_req_d = send_req_q;
        retx_d     = retx_q;
        fail_d     = fail_q;
        init_d     = init_q;
        pld_val_d  = 1'b0;
        rd_d       = rd_q;
        rto_d      = rto_q;
        flush_d    = flush_q;
        retry_d    = retry_q;

        if (wr_en_c) begin
            wr_d = wr_q + 32'd1;
        end

        if (tick_ms && (state_q != XMIT) && (una_q != nxt_q) && !rto_exp_c) begin
            rto_d = rto_q + RTO_W'(1);
        end

        if (wr_q == nxt_q) begin
            flush_d = '0;
        end else if (tick_ms && (state_q == IDLE) && (flush_q < FL_W'(FLUSH_MS))) begin
            flush_d = flush_q + FL_W'(1);
        end

        if (ack_ok_c) begin
            una_d   = rem_ack;
            retry_d = '0;
            rto_d   = '0;
        end

        case (state_q)
            IDLE: begin
                if (!fail_q) begin
                    if (rto_exp_c && (una_q != nxt_q) && !ack_ok_c) begin
                        if (retry_q == RT_W'(MAX_RETRY)) begin
                            fail_d = 1'b1;
                        end else begin
                            send_seq_d = una_q;
                            send_len_d = LEN_W'(seq_min(inflight_c, MSS_SEQ));
                            retry_d    = retry_q + RT_W'(1);
                            retx_d     = 1'b1;
                            send_req_d = 1'b1;
                            state_d    = REQ;
                        end
                    end else if ((unsent_c >= MSS_SEQ) ||
                                 ((unsent_c != '0) && (flush_q >= FL_W'(FLUSH_MS)))) begin
                        send_seq_d = nxt_q;
                        send_len_d = LEN_W'(seq_min(unsent_c, MSS_SEQ));
                        retx_d     = 1'b0;
                        send_req_d = 1'b1;
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                if (eng.send_acc) begin
                    send_req_d = 1'b0;
                    rd_d       = send_seq_q[BUF_AW-1:0];
                    state_d    = XMIT;
                end
            end
            XMIT: begin
                if (rd_en_c) begin
                    rd_d      = rd_q + BUF_AW'(1);
                    pld_val_d = 1'b1;
                end
                if (eng.send_done) begin
                    if (!retx_q) begin
                        nxt_d = nxt_q + 32'(send_len_q);
                    end
                    retx_d  = 1'b0;
                    rto_d   = '0;
                    flush_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Connection (re)initialisation overrides everything in the same cycle.
        if (ini) begin
            state_d    = IDLE;
            wr_d       = tcb.loc_seq;
            una_d      = tcb.loc_seq;
            nxt_d      = tcb.loc_seq;
            send_seq_d = tcb.loc_seq;
            send_len_d = '0;
            send_req_d = 1'b0;
            retx_d     = 1'b0;
            fail_d     = 1'b0;
            init_d     = 1'b1;
            pld_val_d  = 1'b0;
            rto_d      = '0;
            flush_d    = '0;
            retry_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wr_q       <= '0;
            una_q      <= '0;
            nxt_q      <= '0;
            send_seq_q <= '0;
            send_len_q <= '0;
            send_req_q <= 1'b0;
            retx_q     <= 1'b0;
            fail_q     <= 1'b0;
            init_q     <= 1'b0;
            pld_val_q  <= 1'b0;
            rd_q       <= '0;
            rto_q      <= '0;
            flush_q    <= '0;
            retry_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            una_q      <= una_d;
            nxt_q      <= nxt_d;
            send_seq_q <= send_seq_d;
            send_len_q <= send_len_d;
            send_req_q <= send_req_d;
            retx_q     <= retx_d;
            fail_q     <= fail_d;
            init_q     <= init_d;
            pld_val_q  <= pld_val_d;
            rd_q       <= rd_d;
            rto_q      <= rto_d;
            flush_q    <= flush_d;
            retry_q    <= retry_d;
        end
    end

    qnigma_tcp_tx_buf #(
        .AW (BUF_AW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_c),
        .wr_addr (wr_q[BUF_AW-1:0]),
        .wr_dat  (in_dat),
        .rd_en   (rd_en_c),
        .rd_addr (rd_q),
        .rd_dat  (eng.pld_dat)
    );

    assign eng.send_req = send_req_q;
    assign eng.send_seq = send_seq_q;
    assign eng.send_len = send_len_q;
    assign eng.pld_val  = pld_val_q;
    assign loc_seq      = nxt_q;
    assign fail         = fail_q;

endmodule

// File: tb/tb_qnigma_tcp_tx_ctl.sv
// Bench for qnigma_tcp_tx_ctl: random payloads checked against a queue-based sequence-space model.
module tb_qnigma_tcp_tx_ctl;
    import qnigma_pkg::*;

    localparam int unsigned MSS_B   = 1460;
    localparam int unsigned RETRY_B = 5;
    localparam int unsigned BUF_B   = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick_ms = 1'b0;
    tcb_t        tcb = '0;
    logic        ini = 1'b0;
    logic [7:0]  in_dat = '0;
    logic        in_val = 1'b0;
    logic        in_rdy;
    logic [31:0] rem_ack = '0;
    logic        rem_ack_val = 1'b0;
    logic [31:0] loc_seq;
    logic        fail;

    qnigma_tcp_tx_ctl_if eng_if ();

    qnigma_tcp_tx_ctl dut (
        .clk         (clk),
        .rst         (rst),
        .tick_ms     (tick_ms),
        .tcb         (tcb),
        .ini         (ini),
        .in_dat      (in_dat),
        .in_val      (in_val),
        .in_rdy      (in_rdy),
        .rem_ack     (rem_ack),
        .rem_ack_val (rem_ack_val),
        .loc_seq     (loc_seq),
        .fail        (fail),
        .eng         (eng_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bytes held between una and wr, plus the three sequence pointers.
    logic [31:0] m_wr, m_una, m_nxt;
    int          m_retry;
    logic [7:0]  m_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ini(input logic [31:0] seq);
        tcb.loc_seq = seq;
        ini = 1'b1;
        step();
        ini = 1'b0;
        m_wr = seq; m_una = seq; m_nxt = seq; m_retry = 0;
        m_q.delete();
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            tick_ms = 1'b1;
            step();
            tick_ms = 1'b0;
            step();
        end
    endtask

    task automatic write_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            int g = 0;
            in_dat = 8'($urandom);
            in_val = 1'b1;
            while (in_rdy !== 1'b1 && g < 100) begin step(); g++; end
            if (in_rdy !== 1'b1) begin
                n_checks++; n_fail++;
                $display("FAIL write_timeout: in_rdy=%b required 1 at byte %0d", in_rdy, i);
                break;
            end
            m_q.push_back(in_dat);
            m_wr = m_wr + 32'd1;
            step();
        end
        in_val = 1'b0;
    endtask

    task automatic ack(input logic [31:0] val);
        logic [31:0] off;
        rem_ack = val;
        rem_ack_val = 1'b1;
        step();
        rem_ack_val = 1'b0;
        off = val - m_una;
        if (off != 0 && off <= m_nxt - m_una) begin
            for (int i = 0; i < int'(off); i++) void'(m_q.pop_front());
            m_una = val;
            m_retry = 0;
        end
    endtask

    // Acts as the TX engine for one segment, checking header and every payload byte.
    task automatic serve(input bit retx);
        logic [31:0] exp_seq, exp_len, avail;
        int g = 0, bad = 0, base, first_bad = -1;
        logic [7:0] bad_got = '0, bad_exp = '0;
        exp_seq = retx ? m_una : m_nxt;
        avail   = retx ? (m_nxt - m_una) : (m_wr - m_nxt);
        exp_len = (avail < MSS_B) ? avail : MSS_B;
        while (eng_if.send_req !== 1'b1 && g < 40) begin step(); g++; end
        n_checks++;
        if (eng_if.send_req !== 1'b1) begin
            n_fail++;
            $display("FAIL send_req_timeout: send_req=%b required 1", eng_if.send_req);
            return;
        end
        n_checks++;
        if (eng_if.send_seq !== exp_seq) begin
            n_fail++;
            $display("FAIL send_seq: got %h required %h", eng_if.send_seq, exp_seq);
        end
        n_checks++;
        if (eng_if.send_len !== exp_len[15:0]) begin
            n_fail++;
            $display("FAIL send_len: got %0d required %0d", eng_if.send_len, exp_len);
        end
        eng_if.send_acc = 1'b1;
        step();
        eng_if.send_acc = 1'b0;
        base = int'(exp_seq - m_una);
        for (int i = 0; i < int'(exp_len); i++) begin
            eng_if.pld_rd = 1'b1;
            step();
            if (eng_if.pld_val !== 1'b1 || (base + i) >= m_q.size() ||
                eng_if.pld_dat !== m_q[base + i]) begin
                if (first_bad < 0) begin
                    first_bad = i;
                    bad_got = eng_if.pld_dat;
                    bad_exp = ((base + i) < m_q.size()) ? m_q[base + i] : 8'h00;
                end
                bad++;
            end
            if ($urandom_range(0, 7) == 0) begin
                eng_if.pld_rd = 1'b0;
                step();
            end
        end
        eng_if.pld_rd = 1'b0;
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL pld_data: %0d bad bytes, first at %0d got %h required %h",
                     bad, first_bad, bad_got, bad_exp);
        end
        step();
        eng_if.send_done = 1'b1;
        step();
        eng_if.send_done = 1'b0;
        if (retx) m_retry++;
        else      m_nxt = m_nxt + exp_len;
        n_checks++;
        if (loc_seq !== m_nxt) begin
            n_fail++;
            $display("FAIL loc_seq: got %h required %h", loc_seq, m_nxt);
        end
    endtask

    // One RTO period with no ACK: either a retransmission or, when retries are spent, failure.
    task automatic rto_cycle();
        tick(199);
        step(); step(); step();
        n_checks++;
        if (eng_if.send_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rto_early: send_req=%b required 0", eng_if.send_req);
        end
        tick(1);
        if (m_retry == RETRY_B) begin
            step(); step(); step();
            n_checks++;
            if (fail !== 1'b1 || eng_if.send_req !== 1'b0 || in_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL retry_exhausted: fail=%b send_req=%b in_rdy=%b required 1 0 0",
                         fail, eng_if.send_req, in_rdy);
            end
        end else begin
            serve(1'b1);
        end
    endtask

    task automatic test_reset();
        eng_if.send_acc = 1'b0; eng_if.pld_rd = 1'b0; eng_if.send_done = 1'b0;
        rst = 1'b0;
        step(); step();
        n_checks++;
        if ({in_rdy, eng_if.send_req, eng_if.pld_val, fail} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: in_rdy/req/val/fail=%b required 0000",
                     {in_rdy, eng_if.send_req, eng_if.pld_val, fail});
        end
        n_checks++;
        if (eng_if.send_seq !== 32'h0 || eng_if.send_len !== 16'h0 ||
            eng_if.pld_dat !== 8'h0 || loc_seq !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_values: seq=%h len=%h dat=%h loc_seq=%h required zeros",
                     eng_if.send_seq, eng_if.send_len, eng_if.pld_dat, loc_seq);
        end
        rst = 1'b1;
        step(); step();
        n_checks++;
        if (in_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL rdy_before_ini: in_rdy=%b required 0", in_rdy);
        end
        do_ini(32'h0000_1000);
        n_checks++;
        if (in_rdy !== 1'b1 || loc_seq !== 32'h0000_1000) begin
            n_fail++;
            $display("FAIL after_ini: in_rdy=%b loc_seq=%h required 1 00001000", in_rdy, loc_seq);
        end
    endtask

    task automatic test_full_mss();
        write_bytes(MSS_B);
        serve(1'b0);
        n_checks++;
        if (loc_seq !== 32'h0000_15B4) begin
            n_fail++;
            $display("FAIL full_mss_loc_seq: got %h required 000015b4", loc_seq);
        end
        ack(m_nxt);
    endtask

    task automatic test_flush();
        write_bytes(10);
        tick(4);
        step(); step(); step();
        n_checks++;
        if (eng_if.send_req !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_early: send_req=%b required 0", eng_if.send_req);
        end
        tick(1);
        serve(1'b0);
        ack(m_nxt);
    endtask

    task automatic test_rto_fail();
        do_ini($urandom);
        write_bytes(100);
        tick(5);
        serve(1'b0);
        for (int r = 0; r <= RETRY_B; r++) rto_cycle();
        n_checks++;
        if (fail !== 1'b1) begin
            n_fail++;
            $display("FAIL fail_sticky: fail=%b required 1", fail);
        end
    endtask

    task automatic test_partial_ack();
        do_ini($urandom);
        write_bytes(100);
        tick(5);
        serve(1'b0);
        for (int r = 0; r < 3; r++) rto_cycle();
        ack(m_una + 32'd40);
        ack(m_nxt + 32'd5);
        ack(m_una - 32'd10);
        for (int r = 0; r <= RETRY_B; r++) rto_cycle();
        do_ini($urandom);
        n_checks++;
        if (fail !== 1'b0 || in_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL ini_clears_fail: fail=%b in_rdy=%b required 0 1", fail, in_rdy);
        end
    endtask

    task automatic test_wrap();
        do_ini(32'hFFFF_FFF0);
        write_bytes(32);
        tick(5);
        serve(1'b0);
        n_checks++;
        if (loc_seq !== 32'h0000_0010) begin
            n_fail++;
            $display("FAIL wrap_loc_seq: got %h required 00000010", loc_seq);
        end
        ack(32'h0000_0010);
        tick(200);
        step(); step(); step();
        n_checks++;
        if (eng_if.send_req !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_ack: send_req=%b required 0 (ACK not taken)", eng_if.send_req);
        end
    endtask

    task automatic test_buffer_full();
        int acc = 0;
        do_ini($urandom);
        write_bytes(MSS_B);
        serve(1'b0);
        write_bytes(BUF_B - MSS_B);
        n_checks++;
        if (in_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL buf_full: in_rdy=%b required 0", in_rdy);
        end
        in_val = 1'b1;
        for (int i = 0; i < 5; i++) begin in_dat = 8'($urandom); step(); end
        in_val = 1'b0;
        ack(m_una + 32'd1000);
        n_checks++;
        if (in_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL buf_after_ack: in_rdy=%b required 1", in_rdy);
        end
        for (int i = 0; i < 1200; i++) begin
            in_val = 1'b1;
            in_dat = 8'($urandom);
            if (in_rdy === 1'b1) begin
                acc++;
                m_q.push_back(in_dat);
                m_wr = m_wr + 32'd1;
            end
            step();
        end
        in_val = 1'b0;
        n_checks++;
        if (acc !== 1000) begin
            n_fail++;
            $display("FAIL buf_refill_count: accepted %0d required 1000", acc);
        end
        while (m_wr != m_nxt) begin
            if (m_wr - m_nxt < MSS_B) tick(5);
            serve(1'b0);
        end
        ack(m_nxt);
    endtask

    task automatic test_back_to_back();
        do_ini($urandom);
        for (int r = 0; r < 6; r++) begin
            int space, n;
            space = int'(BUF_B) - int'(m_wr - m_una);
            n = $urandom_range(1, (space < 2500) ? space : 2500);
            write_bytes(n);
            while (m_wr != m_nxt) begin
                if (m_wr - m_nxt < MSS_B) tick(5);
                serve(1'b0);
            end
            if (r % 2 == 1) ack(m_nxt);
            else            ack(m_una + 32'($urandom_range(1, int'(m_nxt - m_una))));
        end
    endtask

    initial begin
        test_reset();
        test_full_mss();
        test_flush();
        test_rto_fail();
        test_partial_ack();
        test_wrap();
        test_buffer_full();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/qnigma_tcp_tx_ctl.md
# qnigma_tcp_tx_ctl

Transmit-side control for one TCP connection. It buffers user payload bytes and decides when to form a data segment: either a full MSS has accumulated or a flush timeout has expired. It tracks `snd_una`/`snd_nxt` against remote ACKs and retransmits the oldest unacked segment on RTO. It sits between the user stream and the TCP TX engine, opposite the receive-side ACK/SACK controller.

## Interface
Parameters:
- `BUF_AW`, 12: log2 of payload buffer depth in bytes (4096).
- `MSS`, 1460: maximum payload bytes per segment.
- `FLUSH_MS`, 5: ms that unsent data may wait before a short segment is sent.
- `RTO_MS`, 200: retransmission timeout.
- `MAX_RETRY`, 5: consecutive retransmissions before failure.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `tick_ms`, in, 1: one-cycle pulse every ms.
- `tcb`, in, tcb_t: connection control block; `tcb.loc_seq` is the initial send sequence.
- `ini`, in, 1: pulse; load all pointers from `tcb.loc_seq`, clear timers, retry count and `fail`.
- `in_dat`, in, 8: user payload byte.
- `in_val`, in, 1: user byte valid.
- `in_rdy`, out, 1: buffer can accept a byte this cycle.
- `rem_ack`, in, 32: acknowledgment number from a received segment.
- `rem_ack_val`, in, 1: `rem_ack` valid, one-cycle pulse.
- `loc_seq`, out, 32: current `snd_nxt`.
- `send_req`, out, 1: segment ready for the TX engine.
- `send_acc`, in, 1: engine accepts the request.
- `send_seq`, out, 32: sequence number of the requested segment.
- `send_len`, out, 16: payload length of the requested segment, 1..MSS.
- `pld_rd`, in, 1: engine pulls the next payload byte.
- `pld_dat`, out, 8: payload byte.
- `pld_val`, out, 1: `pld_dat` valid.
- `send_done`, in, 1: engine finished transmitting the segment.
- `fail`, out, 1: retries exhausted; sticky until `ini`.

## Operation
- Pointers are 32-bit sequence numbers `wr`, `una` and `nxt`. All arithmetic is mod 2^32, and comparisons use differences (serial arithmetic).
- `in_rdy = (wr - lock) < 2^BUF_AW && !fail`, where `lock` is `send_seq` during a retransmission, else `una`.
- A write occurs when `in_val && in_rdy`: RAM[`wr[BUF_AW-1:0]`] <= `in_dat`, then `wr++`. When `in_rdy` is low, `in_val` is ignored and the byte is dropped.
- ACK handling: if `rem_ack_val` and `0 < rem_ack - una <= nxt - una`, then `una <= rem_ack`, retry count <= 0 and the RTO timer <= 0. Duplicate, old or beyond-`nxt` ACKs are ignored. ACKs are processed in every state.
- FSM states are IDLE, REQ and XMIT.
  - IDLE, priority 1 (retransmission): if the RTO has expired, `una != nxt` and `!fail`, then `send_seq = una`, `send_len = min(nxt - una, MSS)`, retry++, go to REQ.
  - IDLE, priority 2 (new data): if `wr - nxt >= MSS`, or `wr != nxt` and the flush timer >= FLUSH_MS, then `send_seq = nxt`, `send_len = min(wr - nxt, MSS)`, go to REQ.
  - REQ: `send_req = 1` until `send_acc`; then go to XMIT and set the read pointer to `send_seq`.
  - XMIT: each `pld_rd` returns RAM[`rdptr`] on the next cycle with `pld_val`, and `rdptr` increments. On `send_done`: for new data `nxt += send_len`; the RTO timer restarts; the flush timer clears; go to IDLE.
  - If retry would exceed MAX_RETRY: pulse-set `fail`, stay in IDLE, request nothing further.
- Timers:
  - The RTO timer counts `tick_ms` while `una != nxt` and the state is not XMIT. It saturates at RTO_MS.
  - The flush timer counts `tick_ms` while `wr != nxt` in IDLE. It clears when `wr == nxt`.
- `ini` has priority over all other inputs in the same cycle and forces IDLE from any state.

## Timing
- Reset values: `in_rdy = 0`, `send_req = 0`, `send_seq = 0`, `send_len = 0`, `pld_dat = 0`, `pld_val = 0`, `loc_seq = 0`, `fail = 0`, state IDLE. `in_rdy` stays low until the first `ini`.
- `in_rdy` is combinational from pointers.
- All other outputs are registered.
- `send_req` rises 1 cycle after the IDLE decision.
- The `pld_rd` to `pld_val` latency is exactly 1 cycle.
- `loc_seq` updates the cycle after `send_done`.
- `send_acc` and `send_done` are single-cycle pulses.
- `send_acc` is ignored outside REQ, and `send_done` is ignored outside XMIT.
- A write and a `pld_rd` read in the same cycle are legal because the RAM is dual-port.
- Asserting `rst` mid-XMIT drops the segment; the engine must abort the frame.

## Structure
- `qnigma_pkg` holds the `tx_ctl_state_t` enum (IDLE/REQ/XMIT) and the default MSS/RTO constants; `tcb_t` already lives there.
- One sub-module, `qnigma_tcp_tx_buf`: a simple dual-port byte RAM, 2^BUF_AW deep, 1-cycle read latency.

## Test plan
- Reset test: `ini` with `loc_seq = 0x1000`, write 1460 bytes -> `send_req` with seq 0x1000, len 1460; stream returns bytes in order; after `send_done`, `loc_seq = 0x15B4`.
- Write 10 bytes, stay idle -> after 5 `tick_ms`, one request with len 10 is issued.
- Send 100 bytes with no ACK -> after 200 ms, retransmission with seq = `una`, len 100. After 5 retries -> `fail = 1` and `in_rdy = 0`.
- After a 100-byte send, apply `rem_ack = una + 40` -> `una` advances by 40, the retry count resets, and a later retransmission has len 60. Then `rem_ack` beyond `nxt` -> ignored.
- Start at `loc_seq = 0xFFFF_FFF0`, send 32 bytes -> `loc_seq = 0x10`; an ACK of 0x10 is accepted.
- Fill the buffer to 4096 unacked bytes -> `in_rdy = 0`. ACK 1000 bytes -> `in_rdy = 1`, and exactly 1000 further bytes are accepted.
